switch_debouncer: RTL

//  Conditions the four raw board slide switches before they drive switch_to_led.

---
 rtl/switch_debouncer.sv | 77 +++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Per-bit 2-flop synchroniser and debounce counter for raw slide switches.
// Produces registered clean levels plus one-cycle rise/fall strobes.
module switch_debouncer #(
  parameter  int N_SW            = 4,
  parameter  int DEBOUNCE_CYCLES = 1_000_000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            any_change
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  s1_q, s1_d;
  logic [N_SW-1:0]  s2_q, s2_d;
  logic [N_SW-1:0]  clean_q, clean_d;
  logic [N_SW-1:0]  rise_q, rise_d;
  logic [N_SW-1:0]  fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [N_SW];
  logic [CNT_W-1:0] cnt_d [N_SW];

  // A bit only commits once its synced value has differed for the full count;
  // any agreement with the current clean level restarts the count.
  always_comb begin
    s1_d    = sw_raw;
    s2_d    = s1_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]   = '0;
        clean_d[i] = s2_q[i];
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_clean   = clean_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign any_change = |(rise_q | fall_q);

endmodule
